// File: rtl/alu8_pkg.sv
// Shared types for the alu8 block: opcode enum, result bundle, zero helper.
package alu8_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_PASS = 3'd7
  } alu_op_e;

  // Result plus flags, bundled so comb and register stages move it as one.
  typedef struct packed {
    logic [ALU_W-1:0] y;
    logic             z;
    logic             c;
    logic             v;
  } alu_res_t;

  function automatic logic is_zero(input logic [ALU_W-1:0] x);
    return (x == '0);
  endfunction

endpackage

// File: rtl/alu8_comb.sv
// Pure combinational op/flag logic for alu8. B is never looked at for the
// shift/pass ops, so unknown B bits cannot leak into those results.
module alu8_comb
  import alu8_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  alu_op_e          op,
  output alu_res_t         res
);

  localparam int MSB = ALU_W - 1;

  logic [ALU_W:0] sum_w;
  logic [ALU_W:0] dif_w;

  // Extended add/sub: top bit is carry-out for ADD and borrow for SUB.
  assign sum_w = {1'b0, a} + {1'b0, b};
  assign dif_w = {1'b0, a} - {1'b0, b};

  // Opcode decode; flags default to zero and only arithmetic/shift ops set C/V.
  always_comb begin
    res   = '0;
    res.y = a;
    unique case (op)
      OP_ADD: begin
        res.y = sum_w[MSB:0];
        res.c = sum_w[ALU_W];
        res.v = (a[MSB] & b[MSB] & ~sum_w[MSB]) | (~a[MSB] & ~b[MSB] & sum_w[MSB]);
      end
      OP_SUB: begin
        res.y = dif_w[MSB:0];
        res.c = dif_w[ALU_W];
        res.v = (a[MSB] & ~b[MSB] & ~dif_w[MSB]) | (~a[MSB] & b[MSB] & dif_w[MSB]);
      end
      OP_AND:  res.y = a & b;
      OP_OR:   res.y = a | b;
      OP_XOR:  res.y = a ^ b;
      OP_SHL: begin
        res.y = {a[MSB-1:0], 1'b0};
        res.c = a[MSB];
      end
      OP_SHR: begin
        res.y = {1'b0, a[MSB:1]};
        res.c = a[0];
      end
      OP_PASS: res.y = a;
      default: res.y = a;
    endcase
    res.z = is_zero(res.y);
  end

endmodule

// File: rtl/alu8.sv
// alu8 top: zero-latency ALU outputs plus a 1-cycle registered copy.
// Optional sticky overflow flag built when ALU8_STICKY_V_EN is defined
// (adds clr_sticky input and V_sticky output). Only WIDTH=8 is supported.
module alu8
  import alu8_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
`ifdef ALU8_STICKY_V_EN
  input  logic             clr_sticky,
`endif
  output logic [WIDTH-1:0] Y,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic [WIDTH-1:0] Y_q,
  output logic             Z_q,
  output logic             C_q,
`ifdef ALU8_STICKY_V_EN
  output logic             V_sticky,
`endif
  output logic             V_q
);

  alu_res_t res;
  alu_res_t res_d;
  alu_res_t res_q;

  alu8_comb u_comb (
    .a   (A),
    .b   (B),
    .op  (alu_op_e'(op)),
    .res (res)
  );

  assign Y = res.y;
  assign Z = res.z;
  assign C = res.c;
  assign V = res.v;

  // Next registered value is simply the current combinational result.
  always_comb begin
    res_d = res;
  end

  // Output register; async reset clears result and flags immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_q <= '0;
    else        res_q <= res_d;
  end

  assign Y_q = res_q.y;
  assign Z_q = res_q.z;
  assign C_q = res_q.c;
  assign V_q = res_q.v;

`ifdef ALU8_STICKY_V_EN
  logic v_sticky_d;
  logic v_sticky_q;

  // Sticky overflow: a new overflow beats a same-edge clear.
  always_comb begin
    v_sticky_d = res.v | (v_sticky_q & ~clr_sticky);
  end

  // Sticky flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_sticky_q <= 1'b0;
    else        v_sticky_q <= v_sticky_d;
  end

  assign V_sticky = v_sticky_q;
`endif

endmodule

// File: tb/tb_alu8.sv
// Self-checking bench for alu8: directed table vectors, reset behaviour,
// and random vectors against an integer-arithmetic reference model.
module tb_alu8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] A = '0, B = '0;
  logic [2:0] op = '0;
  logic [7:0] Y, Y_q;
  logic       Z, C, V, Z_q, C_q, V_q;
`ifdef ALU8_STICKY_V_EN
  logic       clr_sticky = 1'b0;
  logic       V_sticky;
`endif

  int total = 0;
  int bad   = 0;
  logic [10:0] sb[$];
  logic sticky_m = 1'b0;

  alu8 dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .op(op),
`ifdef ALU8_STICKY_V_EN
    .clr_sticky(clr_sticky),
`endif
    .Y(Y), .Z(Z), .C(C), .V(V),
    .Y_q(Y_q), .Z_q(Z_q), .C_q(C_q),
`ifdef ALU8_STICKY_V_EN
    .V_sticky(V_sticky),
`endif
    .V_q(V_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic, result packed {Y,Z,C,V}.
  function automatic logic [10:0] model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    int ua = int'(a), ub = int'(b);
    int sa = int'($signed(a)), sbv = int'($signed(b));
    int r;
    logic [7:0] y;
    logic c = 1'b0, v = 1'b0;
    case (o)
      3'd0: begin r = ua + ub; y = 8'(r); c = (r > 255);
                  v = ((sa + sbv) > 127) || ((sa + sbv) < -128); end
      3'd1: begin y = 8'(ua - ub); c = (ua < ub);
                  v = ((sa - sbv) > 127) || ((sa - sbv) < -128); end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: begin y = 8'(ua * 2); c = (ua >= 128); end
      3'd6: begin y = 8'(ua / 2); c = (ua % 2 == 1); end
      default: y = a;
    endcase
    return {y, (y == 8'h00), c, v};
  endfunction

  // Drive one vector mid-cycle, check comb outputs, then check the
  // registered copy (popped from the scoreboard) after the next posedge.
  task automatic step(input string tag, input logic [2:0] o, input logic [7:0] a,
                      input logic [7:0] b, input logic [10:0] exp, input logic clr);
    logic [10:0] e;
    @(negedge clk);
    op = o; A = a; B = b;
`ifdef ALU8_STICKY_V_EN
    clr_sticky = clr;
`endif
    #1;
    chk({tag, "_comb"}, {Y, Z, C, V}, exp);
    sb.push_back(exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_reg"}, {Y_q, Z_q, C_q, V_q}, e);
    end
    sticky_m = exp[0] | (sticky_m & ~clr);
`ifdef ALU8_STICKY_V_EN
    chk({tag, "_stk"}, {10'd0, V_sticky}, {10'd0, sticky_m});
`endif
  endtask

  initial begin
    logic [2:0] ro;
    logic [7:0] ra, rb;
    logic       rc;

    // Reset asserted: registers clear and stay clear across edges.
    #1 rst_n = 1'b0;
    op = 3'd7; A = 8'hA5;
    #1 chk("rst_imm", {Y_q, Z_q, C_q, V_q}, 11'd0);
    repeat (2) @(posedge clk);
    #1 chk("rst_hold", {Y_q, Z_q, C_q, V_q}, 11'd0);
`ifdef ALU8_STICKY_V_EN
    chk("rst_stk", {10'd0, V_sticky}, 11'd0);
`endif
    @(negedge clk) rst_n = 1'b1;

    // Directed table vectors, expectations as {Y, Z, C, V}.
    step("add_ff_01", 3'd0, 8'hFF, 8'h01, {8'h00, 3'b110}, 1'b0);
    step("add_7f_01", 3'd0, 8'h7F, 8'h01, {8'h80, 3'b001}, 1'b1); // set beats clear
    step("sub_00_01", 3'd1, 8'h00, 8'h01, {8'hFF, 3'b010}, 1'b0);
    step("sub_80_01", 3'd1, 8'h80, 8'h01, {8'h7F, 3'b001}, 1'b0);
    step("sub_55_55", 3'd1, 8'h55, 8'h55, {8'h00, 3'b100}, 1'b0);
    step("and",       3'd2, 8'hF0, 8'h3C, {8'h30, 3'b000}, 1'b0);
    step("or",        3'd3, 8'hF0, 8'h3C, {8'hFC, 3'b000}, 1'b0);
    step("xor",       3'd4, 8'hF0, 8'h3C, {8'hCC, 3'b000}, 1'b1); // clears sticky
    step("pass_00",   3'd7, 8'h00, 8'hxx, {8'h00, 3'b100}, 1'b0);
    step("shl_81",    3'd5, 8'h81, 8'hxx, {8'h02, 3'b010}, 1'b0);
    step("shr_01",    3'd6, 8'h01, 8'hxx, {8'h00, 3'b110}, 1'b0);
    step("add_7f_b",  3'd0, 8'h7F, 8'h01, {8'h80, 3'b001}, 1'b0);

    // Reset pulled low between edges clears registers without a clock.
    #2 rst_n = 1'b0;
    #1 chk("rst_mid", {Y_q, Z_q, C_q, V_q}, 11'd0);
`ifdef ALU8_STICKY_V_EN
    chk("rst_mid_stk", {10'd0, V_sticky}, 11'd0);
`endif
    sb.delete();
    sticky_m = 1'b0;
    op = 3'd7; A = 8'h5A; B = 8'h00;
`ifdef ALU8_STICKY_V_EN
    clr_sticky = 1'b0;
`endif
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rel_hold", {Y_q, Z_q, C_q, V_q}, 11'd0);
    @(posedge clk);
    #1 chk("rel_first", {Y_q, Z_q, C_q, V_q}, {8'h5A, 3'b000});

    // Random vectors against the reference model.
    for (int i = 0; i < 220; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = ($urandom_range(0, 3) == 0);
      step("rand", ro, ra, rb, model(ro, ra, rb), rc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
